// File: rtl/bky_ctrl_pkg.sv
// Shared types and constants for the Buckeye load arbiter: FSM states,
// requester indices and default sizing.
package bky_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WAIT = 2'd2,
        CLR  = 2'd3
    } bky_state_e;

    localparam int unsigned REQ_BPI     = 0;
    localparam int unsigned REQ_JTAG    = 1;

    // 6 chips x 48 channels x 3 bits, packed into 16-bit words
    localparam int unsigned NWORDS_DEF  = 54;
    localparam int unsigned TMO_CYC_DEF = 65536;

endpackage

// File: rtl/bky_rr_arb.sv
// Two-way round-robin arbiter. Holds the last-granted record, which resets to
// JTAG so that BPI wins the first tie after reset.
module bky_rr_arb
    import bky_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // One-hot grant: on a tie the requester not served last wins
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            if (last_q == 1'(REQ_JTAG)) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else begin
            gnt = req;
        end
    end

    // Last-granted record follows each committed grant
    always_comb begin
        last_d = last_q;
        if (update && (|req)) begin
            last_d = gnt[REQ_JTAG];
        end else begin
            last_d = last_q;
        end
    end

    // Last-granted register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'(REQ_JTAG);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bky_load_arb.sv
// Buckeye load arbiter: routes one BPI or JTAG load of NWORDS words into the
// loader FIFO, waits for the loader, then clears it. Optional macro BKY_LOAD_TIMEOUT_EN.
module bky_load_arb
    import bky_ctrl_pkg::*;
#(
    parameter int unsigned NWORDS  = NWORDS_DEF,
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic        CLK40,
    input  logic        RST_N,
    input  logic        BPI_REQ,
    input  logic        BPI_VLD,
    input  logic [15:0] BPI_DATA,
    output logic        BPI_RDY,
    input  logic        JTAG_REQ,
    input  logic        JTAG_VLD,
    input  logic [15:0] JTAG_DATA,
    output logic        JTAG_RDY,
    output logic        CAPTURE,
    output logic [15:0] AL_DATA,
    input  logic        AL_FULL,
    input  logic        AL_DONE,
    output logic        CLR_AL_DONE,
    output logic        BUSY,
    output logic [1:0]  GNT,
    output logic [6:0]  WCNT,
    output logic        LOAD_OK,
    output logic        LOAD_TMO
);

    localparam logic [6:0] LAST_IDX = 7'(NWORDS - 1);

    bky_state_e  state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [6:0]  wcnt_q, wcnt_d;
    logic [1:0]  pend_q, pend_d;
    logic        capture_q, capture_d;
    logic [15:0] al_data_q, al_data_d;
    logic        clr_q, clr_d;
    logic        ok_q, ok_d;
    logic        busy_q, busy_d;

    logic [1:0]  req_s;
    logic [1:0]  req_eff_s;
    logic [1:0]  vld_s;
    logic [1:0]  rdy_s;
    logic [1:0]  arb_gnt_s;
    logic        arb_upd_s;
    logic        acc_s;
    logic [15:0] acc_data_s;
    logic        tmo_hit_s;

    assign req_s     = {JTAG_REQ, BPI_REQ};
    assign vld_s     = {JTAG_VLD, BPI_VLD};
    // Requests seen during a load are remembered until the next IDLE
    assign req_eff_s = req_s | pend_q;

    assign rdy_s[REQ_BPI]  = (state_q == XFER) && gnt_q[REQ_BPI]  && !AL_FULL;
    assign rdy_s[REQ_JTAG] = (state_q == XFER) && gnt_q[REQ_JTAG] && !AL_FULL;
    assign acc_s           = |(rdy_s & vld_s);
    assign acc_data_s      = gnt_q[REQ_JTAG] ? JTAG_DATA : BPI_DATA;

    bky_rr_arb u_arb (
        .clk    (CLK40),
        .rst_n  (RST_N),
        .req    (req_eff_s),
        .update (arb_upd_s),
        .gnt    (arb_gnt_s)
    );

`ifdef BKY_LOAD_TIMEOUT_EN
    logic [16:0] wcyc_q, wcyc_d;
    logic        tmo_q, tmo_d;

    assign tmo_hit_s = (state_q == WAIT) && (wcyc_q == 17'(TMO_CYC - 1));

    // WAIT-cycle counter and sticky timeout flag
    always_comb begin
        wcyc_d = 17'd0;
        tmo_d  = tmo_q;
        if (state_q == WAIT) begin
            wcyc_d = wcyc_q + 17'd1;
        end else begin
            wcyc_d = 17'd0;
        end
        if (ok_d) begin
            tmo_d = 1'b0;
        end else if (tmo_hit_s && !AL_DONE) begin
            tmo_d = 1'b1;
        end else begin
            tmo_d = tmo_q;
        end
    end

    // Timeout registers
    always_ff @(posedge CLK40) begin
        if (!RST_N) begin
            wcyc_q <= 17'd0;
            tmo_q  <= 1'b0;
        end else begin
            wcyc_q <= wcyc_d;
            tmo_q  <= tmo_d;
        end
    end

    assign LOAD_TMO = tmo_q;
`else
    // TMO_CYC only matters when the timeout is built in
    logic unused_tmo_cfg_s;
    assign unused_tmo_cfg_s = ^(17'(TMO_CYC));
    assign tmo_hit_s        = 1'b0;
    assign LOAD_TMO         = 1'b0;
`endif

    // Next state, grant, word count and registered output strobes
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        wcnt_d    = wcnt_q;
        arb_upd_s = 1'b0;
        clr_d     = 1'b0;
        ok_d      = 1'b0;
        capture_d = acc_s;
        if (acc_s) begin
            al_data_d = acc_data_s;
        end else begin
            al_data_d = al_data_q;
        end
        if (state_q != IDLE) begin
            pend_d = pend_q | (req_s & ~gnt_q);
        end else begin
            pend_d = pend_q;
        end
        case (state_q)
            IDLE: begin
                if (|req_eff_s) begin
                    arb_upd_s = 1'b1;
                    gnt_d     = arb_gnt_s;
                    pend_d    = pend_q & ~arb_gnt_s;
                    state_d   = XFER;
                end else begin
                    state_d   = IDLE;
                end
            end
            XFER: begin
                if (acc_s) begin
                    wcnt_d = wcnt_q + 7'd1;
                    if (wcnt_q == LAST_IDX) begin
                        state_d = WAIT;
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    state_d = XFER;
                end
            end
            WAIT: begin
                if (AL_DONE) begin
                    state_d = CLR;
                    clr_d   = 1'b1;
                    ok_d    = 1'b1;
                end else if (tmo_hit_s) begin
                    state_d = CLR;
                    clr_d   = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            CLR: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                wcnt_d  = 7'd0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                wcnt_d  = 7'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control and output registers, synchronous active-low reset
    always_ff @(posedge CLK40) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            wcnt_q    <= 7'd0;
            pend_q    <= 2'b00;
            capture_q <= 1'b0;
            al_data_q <= 16'h0000;
            clr_q     <= 1'b0;
            ok_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            wcnt_q    <= wcnt_d;
            pend_q    <= pend_d;
            capture_q <= capture_d;
            al_data_q <= al_data_d;
            clr_q     <= clr_d;
            ok_q      <= ok_d;
            busy_q    <= busy_d;
        end
    end

    assign BPI_RDY     = rdy_s[REQ_BPI];
    assign JTAG_RDY    = rdy_s[REQ_JTAG];
    assign CAPTURE     = capture_q;
    assign AL_DATA     = al_data_q;
    assign CLR_AL_DONE = clr_q;
    assign LOAD_OK     = ok_q;
    assign BUSY        = busy_q;
    assign GNT         = gnt_q;
    assign WCNT        = wcnt_q;

endmodule

// File: tb/tb_bky_load_arb.sv
// Bench for bky_load_arb: directed loads checked every cycle against a
// transaction-level model, plus hand-computed expectations per scenario.
`timescale 1ns/1ps
module tb_bky_load_arb;

    localparam int NW  = 54;
    localparam int TMO = 65536;
`ifdef BKY_LOAD_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        CLK40 = 1'b0;
    logic        RST_N = 1'b0;
    logic        BPI_REQ = 1'b0, BPI_VLD = 1'b0, JTAG_REQ = 1'b0, JTAG_VLD = 1'b0;
    logic [15:0] BPI_DATA = 16'hB000, JTAG_DATA = 16'h4000;
    logic        AL_FULL = 1'b0, AL_DONE = 1'b0;
    logic        BPI_RDY, JTAG_RDY, CAPTURE, CLR_AL_DONE, BUSY, LOAD_OK, LOAD_TMO;
    logic [15:0] AL_DATA;
    logic [1:0]  GNT;
    logic [6:0]  WCNT;

    bky_load_arb #(.NWORDS(NW), .TMO_CYC(TMO)) dut (
        .CLK40(CLK40), .RST_N(RST_N),
        .BPI_REQ(BPI_REQ), .BPI_VLD(BPI_VLD), .BPI_DATA(BPI_DATA), .BPI_RDY(BPI_RDY),
        .JTAG_REQ(JTAG_REQ), .JTAG_VLD(JTAG_VLD), .JTAG_DATA(JTAG_DATA), .JTAG_RDY(JTAG_RDY),
        .CAPTURE(CAPTURE), .AL_DATA(AL_DATA), .AL_FULL(AL_FULL), .AL_DONE(AL_DONE),
        .CLR_AL_DONE(CLR_AL_DONE), .BUSY(BUSY), .GNT(GNT), .WCNT(WCNT),
        .LOAD_OK(LOAD_OK), .LOAD_TMO(LOAD_TMO)
    );

    always #5 CLK40 = ~CLK40;

    int vectors = 0, miscompares = 0;
    int b_idx = 0, j_idx = 0, cyc = 0, n_clr = 0;
    bit full_mode = 1'b0;
    logic [15:0] cap_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 transfer, 2 waiting for loader, 3 clear
    int         m_mode, m_last, m_cnt, m_wcyc;
    logic [1:0] m_gnt, m_pend;
    logic       m_cap, m_clr, m_ok, m_tmo, m_valid = 1'b0;
    logic [15:0] m_data;

    initial forever begin : compare_and_model
        logic [1:0] r;
        logic acc;
        int w;
        @(negedge CLK40);
        if (m_valid) begin
            chk("BPI_RDY",  BPI_RDY,  (m_mode == 1) && (m_gnt == 2'b01) && !AL_FULL);
            chk("JTAG_RDY", JTAG_RDY, (m_mode == 1) && (m_gnt == 2'b10) && !AL_FULL);
            chk("GNT", GNT, m_gnt);
            chk("WCNT", WCNT, m_cnt);
            chk("BUSY", BUSY, m_mode != 0);
            chk("CAPTURE", CAPTURE, m_cap);
            chk("AL_DATA", AL_DATA, m_data);
            chk("CLR_AL_DONE", CLR_AL_DONE, m_clr);
            chk("LOAD_OK", LOAD_OK, m_ok);
            chk("LOAD_TMO", LOAD_TMO, m_tmo);
        end
        if (CAPTURE === 1'b1) cap_q.push_back(AL_DATA);
        if (CLR_AL_DONE === 1'b1) n_clr++;
        // advance the model with the inputs the DUT samples at the next rising edge
        if (!RST_N) begin
            m_mode = 0; m_last = 1; m_cnt = 0; m_wcyc = 0; m_gnt = 2'b00; m_pend = 2'b00;
            m_cap = 1'b0; m_clr = 1'b0; m_ok = 1'b0; m_tmo = 1'b0; m_data = 16'h0000;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_cap = 1'b0; m_clr = 1'b0; m_ok = 1'b0;
            acc = (m_mode == 1) && !AL_FULL &&
                  ((m_gnt == 2'b01 && BPI_VLD) || (m_gnt == 2'b10 && JTAG_VLD));
            if (m_mode != 0) m_pend = m_pend | ({JTAG_REQ, BPI_REQ} & ~m_gnt);
            case (m_mode)
                0: begin
                    r = {JTAG_REQ, BPI_REQ} | m_pend;
                    if (r != 2'b00) begin
                        if (r == 2'b11) w = (m_last == 0) ? 1 : 0;
                        else w = r[1] ? 1 : 0;
                        m_gnt = (w == 0) ? 2'b01 : 2'b10;
                        m_last = w;
                        m_pend[w] = 1'b0;
                        m_mode = 1;
                    end
                end
                1: if (acc) begin
                    m_cap = 1'b1;
                    m_data = (m_gnt == 2'b01) ? BPI_DATA : JTAG_DATA;
                    m_cnt++;
                    if (m_cnt == NW) begin m_mode = 2; m_wcyc = 0; end
                end
                2: begin
                    if (AL_DONE) begin
                        m_mode = 3; m_clr = 1'b1; m_ok = 1'b1; m_tmo = 1'b0;
                    end else if (TMO_ON && m_wcyc == TMO - 1) begin
                        m_mode = 3; m_clr = 1'b1; m_tmo = 1'b1;
                    end else begin
                        m_wcyc++;
                    end
                end
                default: begin m_mode = 0; m_gnt = 2'b00; m_cnt = 0; end
            endcase
        end
    end

    // One clock: note handshakes before the edge, update stimulus just after it
    task automatic step();
        logic ba, ja;
        @(negedge CLK40);
        ba = BPI_VLD & BPI_RDY;
        ja = JTAG_VLD & JTAG_RDY;
        @(posedge CLK40);
        #1;
        if (ba) b_idx++;
        if (ja) j_idx++;
        cyc++;
        BPI_DATA  = 16'hB000 + 16'(b_idx);
        JTAG_DATA = 16'h4000 + 16'(j_idx);
        AL_FULL   = full_mode && (cyc % 3 == 2);
    endtask

    task automatic src_reset();
        b_idx = 0; j_idx = 0;
        BPI_DATA = 16'hB000; JTAG_DATA = 16'h4000;
        cap_q.delete();
    endtask

    task automatic wait_gnt(input string tag, input logic [1:0] exp);
        int k = 0;
        while (GNT == 2'b00 && k < 20) begin step(); k++; end
        chk({tag, "_gnt"}, GNT, exp);
    endtask

    task automatic wait_wcnt(input string tag, input int n);
        int k = 0;
        while (WCNT != 7'(n) && k < 400) begin step(); k++; end
        chk({tag, "_wcnt"}, WCNT, n);
    endtask

    task automatic check_words(input string tag, input logic [15:0] base);
        int bad = 0;
        chk({tag, "_ncap"}, cap_q.size(), NW);
        for (int k = 0; k < cap_q.size(); k++)
            if (k >= NW || cap_q[k] !== base + 16'(k)) bad++;
        chk({tag, "_words"}, bad, 0);
    endtask

    task automatic finish_load(input string tag, input int dly);
        int k = 0;
        repeat (dly) step();
        AL_DONE = 1'b1;
        while (CLR_AL_DONE !== 1'b1 && k < 10) begin step(); k++; end
        chk({tag, "_clr"}, CLR_AL_DONE, 1'b1);
        chk({tag, "_ok"}, LOAD_OK, 1'b1);
        AL_DONE = 1'b0;
        step();
        chk({tag, "_idle_busy"}, BUSY, 1'b0);
        chk({tag, "_idle_gnt"}, GNT, 2'b00);
    endtask

    initial begin : stim
        int c0;
        RST_N = 1'b0;
        repeat (3) step();
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_gnt", GNT, 2'b00);
        chk("rst_wcnt", WCNT, 7'd0);
        chk("rst_data", AL_DATA, 16'h0000);
        chk("rst_strobes", {CAPTURE, CLR_AL_DONE, LOAD_OK, LOAD_TMO, BPI_RDY, JTAG_RDY}, 6'b0);
        RST_N = 1'b1;

        // BPI alone, no backpressure
        src_reset();
        BPI_REQ = 1'b1; BPI_VLD = 1'b1;
        wait_gnt("t1", 2'b01);
        wait_wcnt("t1", NW);
        step();
        check_words("t1", 16'hB000);
        BPI_REQ = 1'b0; BPI_VLD = 1'b0;
        finish_load("t1", 100);

        // Tie from reset: BPI first, JTAG after CLR plus one IDLE cycle
        RST_N = 1'b0; step(); step(); RST_N = 1'b1;
        src_reset();
        BPI_REQ = 1'b1; BPI_VLD = 1'b1; JTAG_REQ = 1'b1; JTAG_VLD = 1'b1;
        wait_gnt("t2a", 2'b01);
        wait_wcnt("t2a", NW);
        step();
        check_words("t2a", 16'hB000);
        BPI_REQ = 1'b0; BPI_VLD = 1'b0;
        finish_load("t2a", 20);
        cap_q.delete();
        step();
        chk("t2b_gnt_after_idle", GNT, 2'b10);
        wait_wcnt("t2b", NW);
        step();
        check_words("t2b", 16'h4000);
        JTAG_REQ = 1'b0; JTAG_VLD = 1'b0;
        finish_load("t2b", 20);

        // Loader FIFO full every third cycle
        src_reset();
        full_mode = 1'b1;
        BPI_REQ = 1'b1; BPI_VLD = 1'b1;
        wait_gnt("t3", 2'b01);
        wait_wcnt("t3", NW);
        step();
        check_words("t3", 16'hB000);
        BPI_REQ = 1'b0; BPI_VLD = 1'b0; full_mode = 1'b0; AL_FULL = 1'b0;
        finish_load("t3", 10);

        // Reset after word 20 abandons the load, then a fresh load from word 0
        src_reset();
        BPI_REQ = 1'b1; BPI_VLD = 1'b1;
        wait_gnt("t4", 2'b01);
        wait_wcnt("t4", 20);
        c0 = n_clr;
        RST_N = 1'b0; step(); RST_N = 1'b1;
        chk("t4_rst_busy", BUSY, 1'b0);
        chk("t4_rst_wcnt", WCNT, 7'd0);
        chk("t4_rst_gnt", GNT, 2'b00);
        chk("t4_no_clr", n_clr - c0, 0);
        src_reset();
        wait_gnt("t4b", 2'b01);
        wait_wcnt("t4b", NW);
        step();
        check_words("t4b", 16'hB000);
        BPI_REQ = 1'b0; BPI_VLD = 1'b0;
        finish_load("t4b", 10);

        // JTAG drops REQ and VLD after word 10; load stalls then completes
        src_reset();
        JTAG_REQ = 1'b1; JTAG_VLD = 1'b1;
        wait_gnt("t5", 2'b10);
        wait_wcnt("t5", 10);
        JTAG_REQ = 1'b0; JTAG_VLD = 1'b0;
        repeat (5) step();
        chk("t5_stall_wcnt", WCNT, 7'd10);
        chk("t5_stall_busy", BUSY, 1'b1);
        chk("t5_stall_gnt", GNT, 2'b10);
        JTAG_VLD = 1'b1;
        wait_wcnt("t5b", NW);
        step();
        check_words("t5", 16'h4000);
        JTAG_VLD = 1'b0;
        finish_load("t5", 10);

`ifdef BKY_LOAD_TIMEOUT_EN
        begin : t6
            int k = 0;
            src_reset();
            BPI_REQ = 1'b1; BPI_VLD = 1'b1;
            wait_gnt("t6", 2'b01);
            wait_wcnt("t6", NW);
            BPI_REQ = 1'b0; BPI_VLD = 1'b0;
            while (CLR_AL_DONE !== 1'b1 && k < 70000) begin step(); k++; end
            chk("t6_tmo_cycles", k, TMO);
            chk("t6_tmo_flag", LOAD_TMO, 1'b1);
            chk("t6_tmo_no_ok", LOAD_OK, 1'b0);
            step();
            chk("t6_tmo_sticky", LOAD_TMO, 1'b1);
            src_reset();
            BPI_REQ = 1'b1; BPI_VLD = 1'b1;
            wait_gnt("t6b", 2'b01);
            wait_wcnt("t6b", NW);
            BPI_REQ = 1'b0; BPI_VLD = 1'b0;
            finish_load("t6b", 5);
            chk("t6_tmo_cleared", LOAD_TMO, 1'b0);
        end
`endif

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
